onehot_reg_bank: RTL and testbench

Register storage stage fed by the write-select decoder tree. Holds DEPTH words of WIDTH bits. A one-hot write-enable vector from the decoder selects which word captures `wr_data` on the rising clock edge. Two independent combinational read ports serve the datapath, and a sticky error flag reports any write-enable vector that is not one-hot.

---
 rtl/onehot_reg_bank.sv | 107 ++++++++++
 tb/tb_onehot_reg_bank.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : onehot_reg_bank
// Purpose  : Register bank of DEPTH words x WIDTH bits. It is written through a
//            one-hot write-enable vector and read through two independent
//            combinational read ports. A sticky error flag records any
//            multi-hot write-enable seen on a clock edge.
//
// Ports    : clk       in   1      rising-edge clock
//            reset     in   1      asynchronous active-high reset
//            wr_en     in   DEPTH  one-hot write select; bit i targets reg i
//            wr_data   in   WIDTH  write data
//            rd_addr1  in   AW     read port 1 address
//            rd_addr2  in   AW     read port 2 address
//            rd_data1  out  WIDTH  reg[rd_addr1]
//            rd_data2  out  WIDTH  reg[rd_addr2]
//            wr_err    out  1      sticky multi-hot write-enable flag
//
// Config   : `ZERO_REG_EN - when defined, register DEPTH-1 is hardwired to
//            zero. It has no storage, and one-hot writes to it are dropped
//            silently.
//
// Revision : 1.0  initial release
// ============================================================================
module onehot_reg_bank #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DEPTH-1:0] wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr1,
  input  logic [AW-1:0]    rd_addr2,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2,
  output logic             wr_err
);

`ifdef ZERO_REG_EN
  localparam bit ZERO_LAST = 1'b1;
`else
  localparam bit ZERO_LAST = 1'b0;
`endif

  localparam logic [DEPTH-1:0] C_ONE = {{(DEPTH-1){1'b0}}, 1'b1};

  // Clearing the lowest set bit leaves a nonzero value only when two or more
  // bits are set. Bit DEPTH-1 takes part even when it is hardwired to zero.
  logic             w_multi_hot;
  logic             wr_err_d;
  logic             wr_err_q;
  logic [WIDTH-1:0] w_reg_val [DEPTH];

  always_comb begin
    w_multi_hot = |(wr_en & (wr_en - C_ONE));
    wr_err_d    = wr_err_q | w_multi_hot;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_err_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      if (ZERO_LAST && (gi == DEPTH - 1)) begin : g_zero
        // This location is a constant zero. It has no storage, so a one-hot
        // write to it has nothing to land in and is lost.
        assign w_reg_val[gi] = '0;
      end else begin : g_store
        logic [WIDTH-1:0] reg_d;
        logic [WIDTH-1:0] reg_q;

        // A multi-hot vector blocks every write, including to bits set in it.
        always_comb begin
          reg_d = reg_q;
          if (wr_en[gi] && !w_multi_hot) begin
            reg_d = wr_data;
          end
        end

        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            reg_q <= '0;
          end else begin
            reg_q <= reg_d;
          end
        end

        assign w_reg_val[gi] = reg_q;
      end
    end
  endgenerate

  // There is no write-to-read bypass. A read always sees the current contents.
  assign rd_data1 = w_reg_val[rd_addr1];
  assign rd_data2 = w_reg_val[rd_addr2];
  assign wr_err   = wr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_onehot_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_onehot_reg_bank
// Purpose  : Self-checking testbench for onehot_reg_bank. A behavioural
//            reference model holds an array of words and a sticky error bit.
//            Each directed and randomized scenario checks the DUT against
//            this model.
// Config   : `ZERO_REG_EN selects the zero-register expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_onehot_reg_bank;

  localparam int WIDTH = 64;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

`ifdef ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic [DEPTH-1:0] wr_en;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rd_addr1;
  logic [AW-1:0]    rd_addr2;
  logic [WIDTH-1:0] rd_data1;
  logic [WIDTH-1:0] rd_data2;
  logic             wr_err;

  int total;
  int bad;

  // Reference model
  logic [WIDTH-1:0] model_mem [DEPTH];
  bit               model_err;

  onehot_reg_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .wr_err   (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] model_read(input int addr);
    if (ZR && addr == DEPTH - 1) return '0;
    return model_mem[addr];
  endfunction

  // Applies the write rules to the model for the clock edge that comes next.
  task automatic model_edge();
    int n;
    int idx;
    n   = 0;
    idx = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) begin
        n++;
        idx = i;
      end
    end
    if (n == 1) model_mem[idx] = wr_data;
    else if (n >= 2) model_err = 1'b1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_err = 1'b0;
  endtask

  // Lets one rising edge occur under model tracking, then samples 1 time unit later.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    model_clear();
    rd_addr1 = 5'd0;
    rd_addr2 = 5'd31;
    #1;
    total++;
    if (rd_data1 !== '0) begin bad++; $display("FAIL reset_rd1_in_reset: got %h exp 0", rd_data1); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (rd_data1 !== '0) begin bad++; $display("FAIL reset_rd1: got %h exp 0", rd_data1); end
    total++;
    if (rd_data2 !== '0) begin bad++; $display("FAIL reset_rd2: got %h exp 0", rd_data2); end
    total++;
    if (wr_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b exp 0", wr_err); end
  endtask

  task automatic test_single_write();
    wr_en   = 32'h0000_0008;
    wr_data = 64'hDEAD_BEEF_0123_4567;
    step();
    wr_en    = '0;
    rd_addr1 = 5'd3;
    rd_addr2 = 5'd3;
    #1;
    total++;
    if (rd_data1 !== 64'hDEAD_BEEF_0123_4567) begin bad++; $display("FAIL single_rd1: got %h exp deadbeef01234567", rd_data1); end
    total++;
    if (rd_data2 !== 64'hDEAD_BEEF_0123_4567) begin bad++; $display("FAIL single_rd2: got %h exp deadbeef01234567", rd_data2); end
    rd_addr1 = 5'd2;
    #1;
    total++;
    if (rd_data1 !== '0) begin bad++; $display("FAIL single_other: got %h exp 0", rd_data1); end
  endtask

  task automatic test_read_during_write();
    wr_en   = 32'h0000_0020;
    wr_data = 64'h1;
    step();
    wr_data  = 64'h2;
    rd_addr1 = 5'd5;
    #1;
    total++;
    if (rd_data1 !== 64'h1) begin bad++; $display("FAIL rdw_before: got %h exp 1", rd_data1); end
    step();
    wr_en = '0;
    total++;
    if (rd_data1 !== 64'h2) begin bad++; $display("FAIL rdw_after: got %h exp 2", rd_data1); end
  endtask

  task automatic test_multi_hot();
    wr_en   = 32'h0000_0001;
    wr_data = 64'h10;
    step();
    wr_en   = 32'h0000_0002;
    wr_data = 64'h11;
    step();
    wr_en   = 32'h0000_0003;
    wr_data = 64'hFF;
    step();
    wr_en    = '0;
    rd_addr1 = 5'd0;
    rd_addr2 = 5'd1;
    #1;
    total++;
    if (rd_data1 !== 64'h10) begin bad++; $display("FAIL multi_reg0: got %h exp 10", rd_data1); end
    total++;
    if (rd_data2 !== 64'h11) begin bad++; $display("FAIL multi_reg1: got %h exp 11", rd_data2); end
    total++;
    if (wr_err !== 1'b1) begin bad++; $display("FAIL multi_err: got %b exp 1", wr_err); end
    wr_en   = 32'h0000_0002;
    wr_data = 64'h77;
    step();
    wr_en = '0;
    #1;
    total++;
    if (rd_data2 !== 64'h77) begin bad++; $display("FAIL multi_followon: got %h exp 77", rd_data2); end
    total++;
    if (wr_err !== 1'b1) begin bad++; $display("FAIL multi_sticky: got %b exp 1", wr_err); end
  endtask

  task automatic test_zero_reg();
    // A fresh reset makes the wr_err check meaningful.
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_clear();
    reset = 1'b0;
    wr_en   = 32'h8000_0000;
    wr_data = 64'hABCD;
    step();
    wr_en    = '0;
    rd_addr1 = 5'd31;
    #1;
    total++;
    if (rd_data1 !== (ZR ? 64'h0 : 64'hABCD)) begin bad++; $display("FAIL zero_reg_read: got %h exp %h", rd_data1, (ZR ? 64'h0 : 64'hABCD)); end
    total++;
    if (wr_err !== 1'b0) begin bad++; $display("FAIL zero_reg_err: got %b exp 0", wr_err); end
    // Bit 31 still takes part in multi-hot detection.
    wr_en   = 32'h8000_0001;
    wr_data = 64'h3;
    step();
    wr_en = '0;
    total++;
    if (wr_err !== 1'b1) begin bad++; $display("FAIL zero_reg_multi: got %b exp 1", wr_err); end
  endtask

  task automatic test_reset_mid();
    wr_en   = 32'h0000_0080;
    wr_data = 64'h55;
    step();
    wr_en   = 32'h0000_0300;
    step();
    wr_en    = '0;
    rd_addr1 = 5'd7;
    #1;
    total++;
    if (rd_data1 !== 64'h55) begin bad++; $display("FAIL mid_pre: got %h exp 55", rd_data1); end
    #1;
    reset = 1'b1;
    #1;
    model_clear();
    total++;
    if (rd_data1 !== '0) begin bad++; $display("FAIL mid_reg7: got %h exp 0", rd_data1); end
    total++;
    if (wr_err !== 1'b0) begin bad++; $display("FAIL mid_err: got %b exp 0", wr_err); end
    // This write lands on an edge while reset is high, so it must be discarded.
    wr_en   = 32'h0000_0080;
    wr_data = 64'h99;
    @(posedge clk);
    #1;
    wr_en = '0;
    reset = 1'b0;
    #1;
    total++;
    if (rd_data1 !== '0) begin bad++; $display("FAIL write_in_reset: got %h exp 0", rd_data1); end
  endtask

  task automatic test_random();
    int sel;
    for (int it = 0; it < 400; it++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 5) wr_en = 32'h1 << $urandom_range(0, DEPTH - 1);
      else if (sel < 7) wr_en = '0;
      else wr_en = $urandom;
      wr_data  = {$urandom, $urandom};
      rd_addr1 = AW'($urandom_range(0, DEPTH - 1));
      rd_addr2 = AW'($urandom_range(0, DEPTH - 1));
      #1;
      // The read ports return the contents from before the edge.
      total++;
      if (rd_data1 !== model_read(int'(rd_addr1))) begin bad++; $display("FAIL rand_pre_rd1 it=%0d: got %h exp %h", it, rd_data1, model_read(int'(rd_addr1))); end
      if ($urandom_range(0, 40) == 0) begin
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_clear();
        reset = 1'b0;
      end
      step();
      total++;
      if (rd_data1 !== model_read(int'(rd_addr1))) begin bad++; $display("FAIL rand_rd1 it=%0d: got %h exp %h", it, rd_data1, model_read(int'(rd_addr1))); end
      total++;
      if (rd_data2 !== model_read(int'(rd_addr2))) begin bad++; $display("FAIL rand_rd2 it=%0d: got %h exp %h", it, rd_data2, model_read(int'(rd_addr2))); end
      total++;
      if (wr_err !== model_err) begin bad++; $display("FAIL rand_err it=%0d: got %b exp %b", it, wr_err, model_err); end
    end
    wr_en = '0;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b0;
    wr_en    = '0;
    wr_data  = '0;
    rd_addr1 = '0;
    rd_addr2 = '0;
    model_clear();
    #2;
    test_reset();
    test_single_write();
    test_read_during_write();
    test_multi_hot();
    test_zero_reg();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
